// File: rtl/time_manager.sv
// Emulated-time scheduler: takes the minimum next-event time over all clock
// generators, issues it on time_next for one cycle, and stops past stop_time.
package time_package;
  localparam int TIME_W = 16;
  typedef logic [TIME_W-1:0] TIME_FORMAT;
  localparam TIME_FORMAT TIME_MAX = '1;
endpackage

module time_manager #(
  parameter int N_CLOCKS  = 2,
  parameter int STEP_BITS = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_CLOCKS*time_package::TIME_W-1:0] time_clocks,
  input  logic                                  run,
  input  logic [time_package::TIME_W-1:0]       stop_time,
  output logic [time_package::TIME_W-1:0]       time_next,
  output logic [time_package::TIME_W-1:0]       time_now,
  output logic [STEP_BITS-1:0]                  step_count,
  output logic                                  done,
  output logic                                  mono_err
);
  localparam int W = time_package::TIME_W;

  typedef enum logic [2:0] {IDLE, SAMPLE, CHECK, HOLD, DONE} state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         cand_q, cand_d;
  logic [W-1:0]         time_next_q, time_next_d;
  logic [W-1:0]         time_now_q, time_now_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 done_q, done_d;
  logic                 mono_q, mono_d;
  logic [W-1:0]         min_all;

  // Unsigned minimum over every clock; only consumed in SAMPLE.
  always_comb begin
    min_all = time_clocks[W-1:0];
    for (int i = 1; i < N_CLOCKS; i++) begin
      if (time_clocks[i*W +: W] < min_all) min_all = time_clocks[i*W +: W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    time_next_d = time_next_q;
    time_now_d  = time_now_q;
    step_d      = step_q;
    done_d      = done_q;
    mono_d      = mono_q;
    case (state_q)
      IDLE: begin
        time_next_d = time_package::TIME_MAX;
        if (run) state_d = SAMPLE;
      end
      SAMPLE: begin
        cand_d  = min_all;
        state_d = CHECK;
      end
      CHECK: begin
        if (cand_q > stop_time) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!run) begin
          state_d = IDLE;
        end else begin
          time_next_d = cand_q;
          time_now_d  = cand_q;
          if (step_q != '1) step_d = step_q + 1'b1;
          if (cand_q < time_now_q) mono_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Clocks matching cand advance at the end of this cycle.
        time_next_d = time_package::TIME_MAX;
        state_d     = SAMPLE;
      end
      DONE: begin
        time_next_d = time_package::TIME_MAX;
      end
      default: begin
        time_next_d = time_package::TIME_MAX;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      time_next_q <= time_package::TIME_MAX;
      time_now_q  <= '0;
      step_q      <= '0;
      done_q      <= 1'b0;
      mono_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      time_next_q <= time_next_d;
      time_now_q  <= time_now_d;
      step_q      <= step_d;
      done_q      <= done_d;
      mono_q      <= mono_d;
    end
  end

  assign time_next  = time_next_q;
  assign time_now   = time_now_q;
  assign step_count = step_q;
  assign done       = done_q;
  assign mono_err   = mono_q;

endmodule

// File: tb/tb_time_manager.sv
// Directed bench for time_manager with two emulated clock generators.
module tb_time_manager;
  localparam int W = 16;
  localparam logic [W-1:0] TMAX = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*W-1:0] time_clocks;
  logic          run;
  logic [W-1:0]  stop_time;
  logic [W-1:0]  time_next;
  logic [W-1:0]  time_now;
  logic [31:0]   step_count;
  logic          done;
  logic          mono_err;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ta, tb;
  bit           auto_mode;
  int           cycle_no;
  int           issue_cnt;
  logic [W-1:0] last_issue;
  int           last_issue_cyc;
  int           fire_cnt;

  time_manager #(.N_CLOCKS(2), .STEP_BITS(32)) dut (
    .clk(clk), .rst(rst), .time_clocks(time_clocks), .run(run),
    .stop_time(stop_time), .time_next(time_next), .time_now(time_now),
    .step_count(step_count), .done(done), .mono_err(mono_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge; in auto mode, clocks matching the issued
  // time advance (A by 10, B by 15), visible to the following SAMPLE.
  task automatic cyc();
    @(negedge clk);
    cycle_no++;
    fire_cnt = 0;
    if (time_next !== TMAX) begin
      issue_cnt++;
      last_issue     = time_next;
      last_issue_cyc = cycle_no;
      if (auto_mode) begin
        if (ta == time_next) begin ta = ta + 10; fire_cnt++; end
        if (tb == time_next) begin tb = tb + 15; fire_cnt++; end
        time_clocks = {tb, ta};
      end
    end
  endtask

  task automatic wait_issue(input string tag);
    int start;
    start = issue_cnt;
    for (int i = 0; i < 20 && issue_cnt == start; i++) cyc();
    if (issue_cnt == start) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=%0d expected=%0d", tag, issue_cnt, start + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [W-1:0] exp_seq [9] = '{0, 10, 15, 20, 30, 40, 45, 50, 60};

  initial begin
    rst = 1'b1; run = 1'b0; stop_time = 60; time_clocks = '0;
    ta = 0; tb = 0; auto_mode = 1'b1;
    cycle_no = 0; issue_cnt = 0; last_issue = '0; last_issue_cyc = 0; fire_cnt = 0;
    #12;
    check("rst_time_next", time_next, TMAX);
    check("rst_time_now", time_now, 0);
    check("rst_step", step_count, 0);
    check("rst_done", done, 0);
    check("rst_mono", mono_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Free-running A=10, B=15, stop at 60.
    run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      int prev_cyc;
      prev_cyc = last_issue_cyc;
      wait_issue("seq");
      check($sformatf("seq_val%0d", k), last_issue, exp_seq[k]);
      if (k > 0) check($sformatf("seq_gap%0d", k), last_issue_cyc - prev_cyc, 3);
      if (k == 0 || k == 4) check($sformatf("seq_both_fire%0d", k), fire_cnt, 2);
    end
    for (int i = 0; i < 10; i++) cyc();
    check("seq_done", done, 1);
    check("seq_step", step_count, 9);
    check("seq_now", time_now, 60);
    check("seq_next_max", time_next, TMAX);
    check("seq_no_extra", issue_cnt, 9);

    // Equal inputs, B held constant while A advances.
    do_reset();
    auto_mode = 1'b0; stop_time = 100; time_clocks = {16'd5, 16'd5}; run = 1'b1;
    wait_issue("eq");
    check("eq_val", last_issue, 5);
    time_clocks = {16'd5, 16'd12};
    wait_issue("eq2");
    check("eq_val2", last_issue, 5);
    time_clocks = {16'd8, 16'd12};
    wait_issue("eq3");
    check("eq_val3", last_issue, 8);
    check("eq_mono", mono_err, 0);

    // Run gating around the HOLD of 20.
    do_reset();
    auto_mode = 1'b1; ta = 0; tb = 0; time_clocks = '0; stop_time = 60; run = 1'b1;
    for (int k = 0; k < 4; k++) wait_issue("gate");
    check("gate_at20", last_issue, 20);
    run = 1'b0;
    begin
      int cnt_before;
      cnt_before = issue_cnt;
      for (int i = 0; i < 10; i++) cyc();
      check("gate_no_issue", issue_cnt, cnt_before);
    end
    check("gate_next_max", time_next, TMAX);
    check("gate_now", time_now, 20);
    check("gate_step", step_count, 4);
    run = 1'b1;
    wait_issue("gate_resume");
    check("gate_resume_val", last_issue, 30);
    check("gate_resume_step", step_count, 5);

    // Stop boundary: equal to stop is issued, one past it ends the run.
    do_reset();
    auto_mode = 1'b0; stop_time = 40; time_clocks = {16'd50, 16'd40}; run = 1'b1;
    wait_issue("stop");
    check("stop_eq_issued", last_issue, 40);
    check("stop_eq_not_done", done, 0);
    time_clocks = {16'd50, 16'd41};
    begin
      int cnt_before;
      cnt_before = issue_cnt;
      for (int i = 0; i < 6; i++) cyc();
      check("stop_no_issue", issue_cnt, cnt_before);
    end
    check("stop_done", done, 1);
    check("stop_step", step_count, 1);
    check("stop_next_max", time_next, TMAX);
    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("stop_done_sticky", done, 1);

    // Monotonicity violation still issues and stays flagged.
    do_reset();
    auto_mode = 1'b0; stop_time = 200; time_clocks = {16'd20, 16'd10}; run = 1'b1;
    wait_issue("mono");
    check("mono_now10", time_now, 10);
    check("mono_clear", mono_err, 0);
    time_clocks = {16'd100, 16'd3};
    wait_issue("mono2");
    check("mono_issue3", last_issue, 3);
    check("mono_set", mono_err, 1);
    time_clocks = {16'd100, 16'd50};
    wait_issue("mono3");
    check("mono_issue50", last_issue, 50);
    check("mono_sticky", mono_err, 1);

    // Asynchronous reset while holding 25.
    do_reset();
    auto_mode = 1'b0; stop_time = 200; time_clocks = {16'd30, 16'd25}; run = 1'b1;
    wait_issue("hrst");
    check("hrst_hold25", time_next, 25);
    rst = 1'b1;
    #1;
    check("hrst_next_max", time_next, TMAX);
    check("hrst_step", step_count, 0);
    check("hrst_now", time_now, 0);
    check("hrst_done", done, 0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int cnt_before;
      cnt_before = issue_cnt;
      for (int i = 0; i < 5; i++) cyc();
      check("hrst_idle", issue_cnt, cnt_before);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
